router_fsm_nport: RTL and testbench
===================================

// Module: router_fsm_nport
// PURPOSE
//  Parametrised N-output router control FSM; successor to the fixed 1x3 router FSM.
//  Sits between the input register block and the N output FIFOs.
//  Decodes the header address, sequences header/payload/parity loads and stalls on FIFO-full.
//  New behaviour: latches the destination, drops packets whose address is >= NUM_PORTS,
//  and counts dropped packets.
// PARAMETERS
//  NUM_PORTS  3  number of output channels, 2..2**ADDR_W
//  ADDR_W     2  header address field width, data_in[ADDR_W-1:0]
//  CNT_W      8  width of saturating dropped-packet counter
// PORTS
//  clock          in   1          single clock, all logic on posedge
//  reset          in   1          synchronous, active-high
//  pkt_valid      in   1          source packet valid; falls with the parity byte
//  data_in        in   ADDR_W     header address bits of the current byte
//  parity_done    in   1          parity byte has been loaded (from register block)
//  low_pkt_valid  in   1          pkt_valid went low while the FSM was stalled on full
//  fifo_full      in   1          full flag of the selected FIFO (muxed externally)
//  fifo_empty     in   NUM_PORTS  per-FIFO empty flags
//  soft_reset     in   NUM_PORTS  per-FIFO soft-reset (read-side timeout)
//  dest_sel       out  NUM_PORTS  one-hot latched destination; 0 when none
//  detect_add, lfd_state, ld_state, laf_state, full_state  out 1  state decodes
//  write_enb_reg  out  1          write enable to the selected FIFO
//  rst_int_reg    out  1          clear internal parity registers
//  busy           out  1          stall the source
//  pkt_dropped    out  1          1-cycle pulse on entry to DROP
//  drop_cnt       out  CNT_W      saturating count of dropped packets
// BEHAVIOUR
//  States: DECODE, LFD, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL (LAF), LOAD_PARITY,
//          CHECK_PARITY (CPE), WAIT_EMPTY, DROP.
//  Reset: state=DECODE, dest_q=0, dest_sel=0, drop_cnt=0, pkt_dropped=0.
//   Outputs follow the state decodes below, so detect_add=1 and busy=0 at reset.
//  DECODE, only when pkt_valid=1:
//   - data_in>=NUM_PORTS -> DROP
//   - else latch dest_q=data_in; fifo_empty[data_in] ? LFD : WAIT_EMPTY
//   - pkt_valid=0 -> stay in DECODE.
//  WAIT_EMPTY: fifo_empty[dest_q] -> LFD, else stay.
//  LFD -> LOAD_DATA unconditionally.
//  LOAD_DATA: fifo_full -> FIFO_FULL; else !pkt_valid -> LOAD_PARITY; else stay.
//  FIFO_FULL: stay while fifo_full, else -> LAF.
//  LAF:
//   - parity_done -> DECODE
//   - else low_pkt_valid -> LOAD_PARITY
//   - else -> LOAD_DATA.
//  LOAD_PARITY -> CPE.
//  CPE: fifo_full -> FIFO_FULL, else -> DECODE.
//  DROP: stay while pkt_valid; pkt_valid=0 -> DECODE. That cycle consumes the parity byte.
//   No writes in DROP; busy=0 so the source drains at full rate.
//  Moore output decodes:
//   - detect_add=DECODE, lfd_state=LFD, ld_state=LOAD_DATA, laf_state=LAF, full_state=FIFO_FULL
//   - write_enb_reg = LOAD_DATA | LOAD_PARITY | LAF
//   - rst_int_reg = CPE
//   - busy = 1 in all states except DECODE, LOAD_DATA, DROP.
//  dest_sel: one-hot of dest_q in every state except DECODE and DROP, where it is 0.
//  Soft reset: soft_reset[dest_q]=1 in any state other than DECODE/DROP forces next
//   state=DECODE. This has priority over all other transitions. soft_reset of other
//   channels is ignored.
//  Drops: pkt_dropped pulses on the DECODE->DROP transition cycle (registered, visible
//   the cycle DROP is entered). drop_cnt increments at the same time and saturates
//   at 2**CNT_W-1.
//  Simultaneous events:
//   - fifo_full and !pkt_valid in LOAD_DATA -> FIFO_FULL wins.
//   - parity_done and low_pkt_valid in LAF -> DECODE wins.
//  Reset mid-packet: returns to DECODE next edge; the upstream FIFO soft reset discards
//   the partial packet.
// STRUCTURE
//  router_defs.vh: state localparams (binary, 4-bit), default widths.
//  Sub-module router_sat_counter #(W) (clock, reset, inc, count) for drop_cnt.
//  FSM next-state/output logic stays in this module.
// TESTING
//  1 reset: assert reset 1 cycle -> detect_add=1, busy=0, dest_sel=0, drop_cnt=0.
//  2 normal pkt: pkt_valid=1, data_in=1, fifo_empty=3'b111
//    -> LFD, LOAD_DATA x3, pkt_valid=0 -> LOAD_PARITY, CPE (rst_int_reg=1), DECODE;
//    dest_sel=3'b010 throughout.
//  3 full stall: fifo_full=1 in LOAD_DATA 2 cycles -> full_state=1, busy=1, write_enb_reg=0;
//    release with low_pkt_valid=1 -> LAF -> LOAD_PARITY.
//  4 wait empty: data_in=2, fifo_empty[2]=0 for 4 cycles -> WAIT_EMPTY, busy=1;
//    fifo_empty[2]=1 -> LFD.
//  5 drop: data_in=3 with NUM_PORTS=3, pkt 5 bytes -> pkt_dropped pulse, write_enb_reg=0,
//    busy=0, drop_cnt=1; repeat 256x with CNT_W=8 -> holds 255.
//  6 soft reset: soft_reset[1]=1 during LOAD_DATA (dest 1) -> DECODE next cycle;
//    soft_reset[0]=1 there -> no effect.

Source files
------------

// File: rtl/router_fsm_nport_pkg.sv
// Shared state encoding, default widths and helpers for the N-port router control FSM.
package router_fsm_nport_pkg;

   localparam int DEF_NUM_PORTS = 3;
   localparam int DEF_ADDR_W    = 2;
   localparam int DEF_CNT_W     = 8;

   typedef enum logic [3:0] {
      ST_DECODE      = 4'd0,
      ST_LFD         = 4'd1,
      ST_LOAD_DATA   = 4'd2,
      ST_FIFO_FULL   = 4'd3,
      ST_LAF         = 4'd4,
      ST_LOAD_PARITY = 4'd5,
      ST_CPE         = 4'd6,
      ST_WAIT_EMPTY  = 4'd7,
      ST_DROP        = 4'd8
   } state_t;

   // States with no destination bound: dest_sel is 0 and soft reset is ignored.
   function automatic logic is_unbound(state_t s);
      return (s == ST_DECODE) || (s == ST_DROP);
   endfunction

endpackage

// File: rtl/router_sat_counter.sv
// Saturating up-counter; increments one cycle after inc, holds at all-ones.
// No backpressure: inc is a single-cycle event input.
module router_sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/router_fsm_nport.sv
// N-output router control FSM: decodes header address, sequences header/payload/parity loads, drops bad addresses.
// Moore outputs decode the current state; busy stalls the source in all states except DECODE, LOAD_DATA and DROP.
module router_fsm_nport
   import router_fsm_nport_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   output logic [NUM_PORTS-1:0] dest_sel,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 write_enb_reg,
   output logic                 rst_int_reg,
   output logic                 busy,
   output logic                 pkt_dropped,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] dest_q;
   logic              addr_ok;
   logic              empty_in;
   logic              empty_q;
   logic              soft_rst_q;
   logic              drop_evt;

   // Loops keep the per-port selects in range when NUM_PORTS < 2**ADDR_W.
   always_comb begin
      addr_ok    = ({1'b0, data_in} < PORT_LIMIT);
      empty_in   = 1'b0;
      empty_q    = 1'b0;
      soft_rst_q = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (data_in == ADDR_W'(i)) begin
            empty_in = fifo_empty[i];
         end
         if (dest_q == ADDR_W'(i)) begin
            empty_q    = fifo_empty[i];
            soft_rst_q = soft_reset[i];
         end
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_DECODE: begin
            if (pkt_valid) begin
               if (!addr_ok)      next_state = ST_DROP;
               else if (empty_in) next_state = ST_LFD;
               else               next_state = ST_WAIT_EMPTY;
            end
         end
         ST_WAIT_EMPTY:  if (empty_q) next_state = ST_LFD;
         ST_LFD:         next_state = ST_LOAD_DATA;
         ST_LOAD_DATA: begin
            if (fifo_full)       next_state = ST_FIFO_FULL;
            else if (!pkt_valid) next_state = ST_LOAD_PARITY;
         end
         ST_FIFO_FULL:   if (!fifo_full) next_state = ST_LAF;
         ST_LAF: begin
            if (parity_done)        next_state = ST_DECODE;
            else if (low_pkt_valid) next_state = ST_LOAD_PARITY;
            else                    next_state = ST_LOAD_DATA;
         end
         ST_LOAD_PARITY: next_state = ST_CPE;
         ST_CPE:         next_state = fifo_full ? ST_FIFO_FULL : ST_DECODE;
         ST_DROP:        if (!pkt_valid) next_state = ST_DECODE;
         default:        next_state = ST_DECODE;
      endcase
      // A read-side timeout on our own channel abandons the packet from any bound state.
      if (!is_unbound(state) && soft_rst_q) begin
         next_state = ST_DECODE;
      end
   end

   assign drop_evt = (state == ST_DECODE) && (next_state == ST_DROP);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_DECODE;
         dest_q      <= '0;
         pkt_dropped <= 1'b0;
      end else begin
         state       <= next_state;
         pkt_dropped <= drop_evt;
         if ((state == ST_DECODE) && pkt_valid && addr_ok) begin
            dest_q <= data_in;
         end
      end
   end

   always_comb begin
      dest_sel = '0;
      if (!is_unbound(state)) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            dest_sel[i] = (dest_q == ADDR_W'(i));
         end
      end
   end

   assign detect_add    = (state == ST_DECODE);
   assign lfd_state     = (state == ST_LFD);
   assign ld_state      = (state == ST_LOAD_DATA);
   assign laf_state     = (state == ST_LAF);
   assign full_state    = (state == ST_FIFO_FULL);
   assign write_enb_reg = (state == ST_LOAD_DATA) || (state == ST_LOAD_PARITY) || (state == ST_LAF);
   assign rst_int_reg   = (state == ST_CPE);
   assign busy          = !((state == ST_DECODE) || (state == ST_LOAD_DATA) || (state == ST_DROP));

   router_sat_counter #(
      .W (CNT_W)
   ) u_drop_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (drop_evt),
      .count (drop_cnt)
   );

endmodule

// File: tb/tb_router_fsm_nport.sv
// Self-checking bench for router_fsm_nport: directed scenarios plus randomized traffic against a behavioural model.
module tb_router_fsm_nport;

   localparam int NP = 3;
   localparam int AW = 2;
   localparam int CW = 8;
   localparam int VW = NP + 9 + CW;

   // Expected {detect,lfd,ld,laf,full,write,rst_int,busy} per state
   localparam logic [7:0] D_DEC  = 8'b1000_0000;
   localparam logic [7:0] D_LFD  = 8'b0100_0001;
   localparam logic [7:0] D_LD   = 8'b0010_0100;
   localparam logic [7:0] D_LAF  = 8'b0001_0101;
   localparam logic [7:0] D_FULL = 8'b0000_1001;
   localparam logic [7:0] D_LP   = 8'b0000_0101;
   localparam logic [7:0] D_CPE  = 8'b0000_0011;
   localparam logic [7:0] D_WAIT = 8'b0000_0001;
   localparam logic [7:0] D_DROP = 8'b0000_0000;

   logic          clock;
   logic          reset;
   logic          pkt_valid;
   logic [AW-1:0] data_in;
   logic          parity_done;
   logic          low_pkt_valid;
   logic          fifo_full;
   logic [NP-1:0] fifo_empty;
   logic [NP-1:0] soft_reset;
   logic [NP-1:0] dest_sel;
   logic          detect_add, lfd_state, ld_state, laf_state, full_state;
   logic          write_enb_reg, rst_int_reg, busy, pkt_dropped;
   logic [CW-1:0] drop_cnt;

   int tests_run;
   int tests_failed;

   router_fsm_nport #(
      .NUM_PORTS (NP),
      .ADDR_W    (AW),
      .CNT_W     (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .soft_reset    (soft_reset),
      .dest_sel      (dest_sel),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .write_enb_reg (write_enb_reg),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy),
      .pkt_dropped   (pkt_dropped),
      .drop_cnt      (drop_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   wire [7:0]    obs_dec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                            write_enb_reg, rst_int_reg, busy};
   wire [VW-1:0] obs_vec = {dest_sel, obs_dec, pkt_dropped, drop_cnt};

   // Behavioural model: packet phase, bound destination, drop pulse and drop total
   typedef enum int {M_DEC, M_LFD, M_LD, M_FULL, M_LAF, M_LP, M_CPE, M_WAIT, M_DROP} mph_t;
   mph_t m_ph;
   int   m_dest;
   bit   m_pulse;
   int   m_drops;

   function automatic logic [VW-1:0] exp_vec();
      logic [NP-1:0] sel;
      logic [7:0]    dec;
      sel = (m_ph == M_DEC || m_ph == M_DROP) ? '0 : NP'(1) << m_dest;
      case (m_ph)
         M_DEC:   dec = D_DEC;
         M_LFD:   dec = D_LFD;
         M_LD:    dec = D_LD;
         M_LAF:   dec = D_LAF;
         M_FULL:  dec = D_FULL;
         M_LP:    dec = D_LP;
         M_CPE:   dec = D_CPE;
         M_WAIT:  dec = D_WAIT;
         default: dec = D_DROP;
      endcase
      return {sel, dec, m_pulse, CW'(m_drops > 255 ? 255 : m_drops)};
   endfunction

   // Advance one clock edge and move the model by the same rules the router follows.
   task automatic tick();
      mph_t n_ph;
      int   n_dest;
      bit   n_pulse;
      n_ph = m_ph; n_dest = m_dest; n_pulse = 1'b0;
      if (reset) begin
         n_ph = M_DEC; n_dest = 0; m_drops = 0;
      end else begin
         case (m_ph)
            M_DEC: if (pkt_valid) begin
               if (int'(data_in) >= NP) n_ph = M_DROP;
               else begin
                  n_dest = int'(data_in);
                  n_ph   = fifo_empty[n_dest] ? M_LFD : M_WAIT;
               end
            end
            M_WAIT:  if (fifo_empty[m_dest]) n_ph = M_LFD;
            M_LFD:   n_ph = M_LD;
            M_LD:    if (fifo_full) n_ph = M_FULL; else if (!pkt_valid) n_ph = M_LP;
            M_FULL:  if (!fifo_full) n_ph = M_LAF;
            M_LAF:   n_ph = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
            M_LP:    n_ph = M_CPE;
            M_CPE:   n_ph = fifo_full ? M_FULL : M_DEC;
            default: if (!pkt_valid) n_ph = M_DEC;
         endcase
         if (m_ph != M_DEC && m_ph != M_DROP && soft_reset[m_dest]) n_ph = M_DEC;
         n_pulse = (m_ph == M_DEC) && (n_ph == M_DROP);
         if (n_pulse) m_drops++;
      end
      @(posedge clock);
      #1;
      m_ph = n_ph; m_dest = n_dest; m_pulse = n_pulse;
   endtask

   task automatic idle_inputs();
      pkt_valid = 1'b0; data_in = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
      fifo_full = 1'b0; fifo_empty = '1; soft_reset = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if ({detect_add, busy, dest_sel, drop_cnt, pkt_dropped} !== {1'b1, 1'b0, 3'b000, 8'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b want %b",
                  {detect_add, busy, dest_sel, drop_cnt, pkt_dropped}, {1'b1, 1'b0, 3'b000, 8'd0, 1'b0});
      end
      tests_run++;
      if (obs_vec !== exp_vec()) begin
         tests_failed++;
         $display("FAIL reset_vec: got %h want %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_normal_pkt();
      logic       pv [0:6];
      logic [7:0] ed [0:6];
      pv = '{1, 1, 1, 1, 0, 0, 0};
      ed = '{D_LFD, D_LD, D_LD, D_LD, D_LP, D_CPE, D_DEC};
      idle_inputs();
      data_in = 2'd1;
      for (int c = 0; c < 7; c++) begin
         pkt_valid = pv[c];
         tick();
         tests_run++;
         if ({obs_dec, dest_sel} !== {ed[c], (c < 6) ? 3'b010 : 3'b000}) begin
            tests_failed++;
            $display("FAIL normal_seq cyc %0d: got %b want %b", c, {obs_dec, dest_sel},
                     {ed[c], (c < 6) ? 3'b010 : 3'b000});
         end
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL normal_vec cyc %0d: got %h want %h", c, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_full_stall();
      logic       pv [0:7];
      logic       ff [0:7];
      logic       lp [0:7];
      logic [7:0] ed [0:7];
      pv = '{1, 1, 0, 0, 0, 0, 0, 0};
      ff = '{0, 0, 1, 1, 0, 0, 0, 0};
      lp = '{0, 0, 0, 0, 1, 1, 0, 0};
      ed = '{D_LFD, D_LD, D_FULL, D_FULL, D_LAF, D_LP, D_CPE, D_DEC};
      idle_inputs();
      data_in = 2'd0;
      for (int c = 0; c < 8; c++) begin
         pkt_valid = pv[c]; fifo_full = ff[c]; low_pkt_valid = lp[c];
         tick();
         tests_run++;
         if ({obs_dec, dest_sel} !== {ed[c], (c < 7) ? 3'b001 : 3'b000}) begin
            tests_failed++;
            $display("FAIL full_seq cyc %0d: got %b want %b", c, {obs_dec, dest_sel},
                     {ed[c], (c < 7) ? 3'b001 : 3'b000});
         end
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL full_vec cyc %0d: got %h want %h", c, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_wait_empty();
      logic       pv [0:9];
      logic [7:0] ed [0:9];
      pv = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      ed = '{D_WAIT, D_WAIT, D_WAIT, D_WAIT, D_WAIT, D_LFD, D_LD, D_LP, D_CPE, D_DEC};
      idle_inputs();
      data_in = 2'd2;
      for (int c = 0; c < 10; c++) begin
         pkt_valid  = pv[c];
         fifo_empty = (c < 5) ? 3'b011 : 3'b111;
         tick();
         tests_run++;
         if ({obs_dec, dest_sel} !== {ed[c], (c < 9) ? 3'b100 : 3'b000}) begin
            tests_failed++;
            $display("FAIL wait_seq cyc %0d: got %b want %b", c, {obs_dec, dest_sel},
                     {ed[c], (c < 9) ? 3'b100 : 3'b000});
         end
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL wait_vec cyc %0d: got %h want %h", c, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_soft_reset();
      logic          pv [0:4];
      logic [NP-1:0] sr [0:4];
      logic [7:0]    ed [0:4];
      logic [NP-1:0] es [0:4];
      pv = '{1, 1, 1, 1, 0};
      sr = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000};
      ed = '{D_LFD, D_LD, D_LD, D_DEC, D_DEC};
      es = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
      idle_inputs();
      data_in = 2'd1;
      for (int c = 0; c < 5; c++) begin
         pkt_valid = pv[c]; soft_reset = sr[c];
         tick();
         tests_run++;
         if ({obs_dec, dest_sel} !== {ed[c], es[c]}) begin
            tests_failed++;
            $display("FAIL soft_seq cyc %0d: got %b want %b", c, {obs_dec, dest_sel}, {ed[c], es[c]});
         end
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL soft_vec cyc %0d: got %h want %h", c, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_drop();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      // 5-byte packet to port 3: header, 3 payload bytes, parity
      for (int c = 0; c < 5; c++) begin
         pkt_valid = (c < 4);
         data_in   = (c == 0) ? 2'd3 : 2'($urandom_range(0, 3));
         tick();
         tests_run++;
         if ({pkt_dropped, obs_dec, dest_sel, drop_cnt} !==
             {c == 0, (c < 4) ? D_DROP : D_DEC, 3'b000, 8'd1}) begin
            tests_failed++;
            $display("FAIL drop_pkt cyc %0d: got %b want %b", c,
                     {pkt_dropped, obs_dec, dest_sel, drop_cnt},
                     {c == 0, (c < 4) ? D_DROP : D_DEC, 3'b000, 8'd1});
         end
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL drop_vec cyc %0d: got %h want %h", c, obs_vec, exp_vec());
         end
      end
      for (int n = 0; n < 256; n++) begin
         pkt_valid = 1'b1; data_in = 2'd3;
         tick();
         pkt_valid = 1'b0;
         tick();
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL drop_rep_vec n %0d: got %h want %h", n, obs_vec, exp_vec());
         end
      end
      tests_run++;
      if (drop_cnt !== 8'd255) begin
         tests_failed++;
         $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
      end
   endtask

   task automatic test_random();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         pkt_valid     = ($urandom_range(0, 7) != 0);
         data_in       = 2'($urandom_range(0, 3));
         fifo_full     = ($urandom_range(0, 3) == 0);
         fifo_empty    = 3'($urandom);
         soft_reset    = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
         parity_done   = ($urandom_range(0, 3) == 0);
         low_pkt_valid = ($urandom_range(0, 3) == 0);
         reset         = ($urandom_range(0, 299) == 0);
         tick();
         tests_run++;
         if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL random_vec cyc %0d: got %h want %h", c, obs_vec, exp_vec());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      m_ph = M_DEC; m_dest = 0; m_pulse = 1'b0; m_drops = 0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_normal_pkt();
      test_full_stall();
      test_wait_empty();
      test_soft_reset();
      test_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
